microseq_unit: RTL and testbench

Parametrised microprogram sequencer for the control unit. It holds a writable control store, a micro-PC (upc) and next-address logic. It replaces the fixed address-to-control-word lookup. Each cycle it outputs the registered control word for the current upc and computes the next address from the word's sequencing fields: sequential, jump, conditional branch, or opcode dispatch.

---
 rtl/microseq_unit.sv | 152 +++++++++++++++
 tb/tb_microseq_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/microseq_unit.sv
// microseq_unit: microprogram sequencer with a writable control store.
// Each cycle it fetches the control word for the next micro-PC and holds it in
// cs_q. The next address comes from the sequencing fields of the current word:
// sequential, jump, conditional branch or opcode dispatch.
// Optional feature macro: MICROSEQ_CALL_STACK_EN adds a 4-entry return stack
// for CALL/RET. When the macro is undefined, CALL/RET behave as SEQ and
// stack_err is tied low.
// Word layout (MSB->LSB): ctrl[CTRL_W], mode[3], csel[CSEL_W], next_addr[AW].
module microseq_unit #(
  parameter int    AW         = 5,
  parameter int    CTRL_W     = 30,
  parameter int    CSEL_W     = 2,
  parameter int    RESET_ADDR = 0,
  parameter string INIT_FILE  = ""
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          stall,
  input  logic [(2**CSEL_W)-1:0]        cond_in,
  input  logic [AW-1:0]                 dispatch_addr,
  input  logic                          wr_en,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [CTRL_W+3+CSEL_W+AW-1:0] wr_data,
  output logic [CTRL_W-1:0]             ctrl_out,
  output logic [AW-1:0]                 upc_out,
  output logic                          valid,
  output logic                          stack_err
);

  localparam int WORD_W = CTRL_W + 3 + CSEL_W + AW;
  localparam int DEPTH  = 2**AW;

  localparam logic [AW-1:0] RST_A = AW'(RESET_ADDR);
  localparam logic [AW-1:0] ONE_A = AW'(1);

  localparam logic [2:0] M_SEQ  = 3'd0;
  localparam logic [2:0] M_JMP  = 3'd1;
  localparam logic [2:0] M_BR   = 3'd2;
  localparam logic [2:0] M_DISP = 3'd3;
`ifdef MICROSEQ_CALL_STACK_EN
  localparam logic [2:0] M_CALL = 3'd4;
  localparam logic [2:0] M_RET  = 3'd5;
`endif

  logic [WORD_W-1:0] store [DEPTH];
  logic [AW-1:0]     upc;
  logic [WORD_W-1:0] cs_q;
  logic [AW-1:0]     upc_inc;
  logic [AW-1:0]     next;

  // Sequencing fields of the word currently held in cs_q.
  logic [2:0]        mode_f;
  logic [CSEL_W-1:0] csel_f;
  logic [AW-1:0]     na_f;

  assign mode_f  = cs_q[AW+CSEL_W+2 -: 3];
  assign csel_f  = cs_q[AW+CSEL_W-1 -: CSEL_W];
  assign na_f    = cs_q[AW-1:0];
  assign upc_inc = upc + ONE_A;

  assign ctrl_out = cs_q[WORD_W-1 -: CTRL_W];
  assign upc_out  = upc;

`ifdef MICROSEQ_CALL_STACK_EN
  logic [AW-1:0] stk [4];
  logic [2:0]    sp;
  logic [1:0]    sp_top;
  logic          push;
  logic          pop;
  logic          err_set;

  assign sp_top = sp[1:0] - 2'd1;
`endif

  // Next-address selection from the current word's sequencing fields.
  always_comb begin
    next = upc_inc;
`ifdef MICROSEQ_CALL_STACK_EN
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
`endif
    if (!valid) begin
      next = RST_A;
    end else begin
      case (mode_f)
        M_SEQ:  next = upc_inc;
        M_JMP:  next = na_f;
        M_BR:   next = cond_in[csel_f] ? na_f : upc_inc;
        M_DISP: next = dispatch_addr;
`ifdef MICROSEQ_CALL_STACK_EN
        M_CALL: begin
          next = na_f;
          // A call on a full stack still jumps, but the return is lost.
          if (sp == 3'd4) err_set = 1'b1;
          else            push    = 1'b1;
        end
        M_RET: begin
          if (sp == 3'd0) begin
            next    = RST_A;
            err_set = 1'b1;
          end else begin
            next = stk[sp_top];
            pop  = 1'b1;
          end
        end
`endif
        default: next = upc_inc;
      endcase
    end
  end

  // Fetch: advance upc and register the addressed word unless stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upc   <= RST_A;
      cs_q  <= '0;
      valid <= 1'b0;
    end else if (!stall) begin
      upc   <= next;
      cs_q  <= store[next];
      valid <= 1'b1;
    end
  end

  // Control-store write port; independent of stall, dropped during reset.
  // The fetch above reads the pre-write contents on a same-edge collision.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) store[wr_addr] <= wr_data;
  end

`ifdef MICROSEQ_CALL_STACK_EN
  // Return stack: push/pop on non-stalled cycles, sticky error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp        <= 3'd0;
      stack_err <= 1'b0;
    end else if (!stall) begin
      if (push) begin
        stk[sp[1:0]] <= upc_inc;
        sp           <= sp + 3'd1;
      end else if (pop) begin
        sp <= sp - 3'd1;
      end
      if (err_set) stack_err <= 1'b1;
    end
  end
`else
  assign stack_err = 1'b0;
`endif

endmodule

// File: tb/tb_microseq_unit.sv
// Scoreboard bench for microseq_unit: a behavioural model predicts the
// outputs after each clock edge and queues them; a monitor compares them
// against the DUT on the falling edge.
module tb_microseq_unit;

  localparam int AW     = 5;
  localparam int CTRL_W = 30;
  localparam int CSEL_W = 2;
  localparam int WORD_W = CTRL_W + 3 + CSEL_W + AW;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall;
  logic [3:0]        cond_in;
  logic [AW-1:0]     dispatch_addr;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic [CTRL_W-1:0] ctrl_out;
  logic [AW-1:0]     upc_out;
  logic              valid;
  logic              stack_err;

  microseq_unit #(
    .AW(AW), .CTRL_W(CTRL_W), .CSEL_W(CSEL_W), .RESET_ADDR(0), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .cond_in(cond_in),
    .dispatch_addr(dispatch_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .ctrl_out(ctrl_out), .upc_out(upc_out),
    .valid(valid), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [AW-1:0]     upc;
    logic              vld;
    logic              err;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state
  logic [WORD_W-1:0] m_store [DEPTH];
  int                m_upc   = 0;
  bit                m_valid = 1'b0;
  logic [WORD_W-1:0] m_word  = '0;
  int                m_stack[$];
  bit                m_err   = 1'b0;

  function automatic logic [WORD_W-1:0] mkw(int mode, int csel, int na);
    logic [CTRL_W-1:0] c;
    logic [2:0]        m;
    logic [1:0]        cs;
    logic [4:0]        a;
    c  = CTRL_W'($urandom);
    m  = 3'(mode);
    cs = 2'(csel);
    a  = 5'(na);
    return {c, m, cs, a};
  endfunction

  // Apply the edge that just happened to the model, using the driven inputs.
  task automatic model_edge();
    int nxt, mode, csel, na;
    if (!rst_n) begin
      m_upc   = 0;
      m_word  = '0;
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_stack.delete();
      return;
    end
    if (!stall) begin
      mode = int'(m_word[9:7]);
      csel = int'(m_word[6:5]);
      na   = int'(m_word[4:0]);
      if (!m_valid) nxt = 0;
      else begin
        case (mode)
          1: nxt = na;
          2: nxt = cond_in[csel] ? na : (m_upc + 1) % DEPTH;
          3: nxt = int'(dispatch_addr);
`ifdef MICROSEQ_CALL_STACK_EN
          4: begin
            if (m_stack.size() == 4) m_err = 1'b1;
            else m_stack.push_back((m_upc + 1) % DEPTH);
            nxt = na;
          end
          5: begin
            if (m_stack.size() == 0) begin
              m_err = 1'b1;
              nxt   = 0;
            end else nxt = m_stack.pop_back();
          end
`endif
          default: nxt = (m_upc + 1) % DEPTH;
        endcase
      end
      m_upc   = nxt;
      m_word  = m_store[nxt];
      m_valid = 1'b1;
    end
    if (wr_en) m_store[wr_addr] = wr_data;
  endtask

  task automatic step(bit r, bit s, logic [3:0] c, int d, bit we, int wa,
                      logic [WORD_W-1:0] wd);
    exp_t e;
    rst_n = r; stall = s; cond_in = c; dispatch_addr = AW'(d);
    wr_en = we; wr_addr = AW'(wa); wr_data = wd;
    @(posedge clk);
    model_edge();
    e.ctrl = m_word[WORD_W-1 -: CTRL_W];
    e.upc  = AW'(m_upc);
    e.vld  = m_valid;
    e.err  = m_err;
    sbq.push_back(e);
    #1;
  endtask

  task automatic load(int a, logic [WORD_W-1:0] w);
    step(1'b1, 1'b1, 4'b0000, 0, 1'b1, a, w);
  endtask

  task automatic run_until(int target, logic [3:0] c, int d, int maxc);
    for (int i = 0; i < maxc; i++) begin
      step(1'b1, 1'b0, c, d, 1'b0, 0, '0);
      if (m_valid && m_upc == target) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL reach_upc: model upc %0d, required %0d within %0d cycles",
             m_upc, target, maxc);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: pop one prediction per cycle and compare against the DUT.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("valid",     32'(valid),     32'(e.vld));
      chk("upc_out",   32'(upc_out),   32'(e.upc));
      chk("ctrl_out",  32'(ctrl_out),  32'(e.ctrl));
      chk("stack_err", 32'(stack_err), 32'(e.err));
    end
  end

  initial begin
    // Reset, then fill the store while stalled so nothing uninitialised is fetched.
    step(1'b0, 1'b0, 4'b0000, 0, 1'b0, 0, '0);
    step(1'b0, 1'b1, 4'b0000, 0, 1'b1, 3, '1);
    for (int a = 0; a < DEPTH; a++) load(a, mkw(0, 0, 0));
    load(1,  mkw(1, 0, 7));
    load(7,  mkw(1, 0, 5));
    load(5,  mkw(2, 1, 20));
    load(20, mkw(1, 0, 5));
    load(6,  mkw(3, 0, 0));
    load(9,  mkw(1, 0, 18));
    load(18, mkw(1, 0, 31));

    // Sequential, jump, branch taken, branch not taken.
    run_until(20, 4'b0010, 0, 10);
    run_until(6, 4'b0000, 0, 10);

    // Dispatch under stall; dispatch_addr changes before stall drops.
    step(1'b1, 1'b1, 4'b0000, 13, 1'b0, 0, '0);
    step(1'b1, 1'b1, 4'b0000, 13, 1'b0, 0, '0);
    step(1'b1, 1'b1, 4'b0000, 9,  1'b0, 0, '0);
    step(1'b1, 1'b0, 4'b0000, 9,  1'b0, 0, '0);
    run_until(18, 4'b0000, 9, 5);

    // Reset while stalled with a pending write: write must be dropped.
    step(1'b0, 1'b1, 4'b0000, 9, 1'b1, 18, mkw(0, 0, 0));

    // Wrap 31 -> 0 with a same-edge write to address 0.
    run_until(31, 4'b0000, 9, 20);
    step(1'b1, 1'b0, 4'b0000, 9, 1'b1, 0, mkw(0, 0, 0));
    run_until(0, 4'b0000, 9, 20);
    step(1'b1, 1'b0, 4'b0000, 9, 1'b0, 0, '0);

    // Call/return program (plain sequencing when the stack is compiled out).
    step(1'b0, 1'b1, 4'b0000, 0, 1'b0, 0, '0);
    for (int a = 0; a < DEPTH; a++) load(a, mkw(0, 0, 0));
    load(3,  mkw(4, 0, 10));
    load(10, mkw(5, 0, 0));
    load(4,  mkw(4, 0, 20));
    load(20, mkw(4, 0, 22));
    load(22, mkw(4, 0, 24));
    load(24, mkw(4, 0, 26));
    load(26, mkw(4, 0, 28));
    load(28, mkw(5, 0, 0));
    load(25, mkw(5, 0, 0));
    load(23, mkw(5, 0, 0));
    load(21, mkw(5, 0, 0));
    load(5,  mkw(5, 0, 0));
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 4'b0000, 0, 1'b0, 0, '0);

    // Randomised phase: random words, conditions, stalls, writes and resets.
    step(1'b0, 1'b0, 4'b0000, 0, 1'b0, 0, '0);
    for (int a = 0; a < DEPTH; a++)
      load(a, mkw($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 31)));
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) >= 2,
           $urandom_range(0, 99) < 20,
           4'($urandom),
           $urandom_range(0, 31),
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 31),
           mkw($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 31)));
    end

    // Let the monitor drain the queue.
    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d predictions left, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
